// File: rtl/multi_port_reg_file_pkg.sv
// Shared constants for the multi-port register file and its scoreboard.
// Default geometry matches the classic 32x32 MIPS register file.
package multi_port_reg_file_pkg;

    localparam int REG_ZERO   = 0;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/multi_port_reg_file_scoreboard.sv
// Per-register busy scoreboard: reservations set a bit, writebacks clear it.
// A reservation outranks a same-cycle write to the same register (newer producer).
module multi_port_reg_file_scoreboard
    import multi_port_reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_WR = 1
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    output logic [2**ADDR_W-1:0]     busy
);

    logic [2**ADDR_W-1:0] r_busy;

    // Clears are applied first so that the reservation assignment lands last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k]) begin
                    r_busy[wr_addr[k*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            if (rsv_en) begin
                r_busy[rsv_addr] <= 1'b1;
            end
        end
    end

    assign busy = r_busy;

endmodule

// File: rtl/multi_port_reg_file.sv
// Parametrised N-read / M-write register file with optional hardwired zero register,
// write-through bypass and a busy scoreboard for the ID/WB stages.
module multi_port_reg_file
    import multi_port_reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [2**ADDR_W-1:0]     busy
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [NUM_WR-1:0] w_wr_en;
    logic              w_rsv_en;

    // Writes and reservations aimed at the hardwired zero register are filtered out here,
    // so storage, bypass and scoreboard never see them.
    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_filter
        assign w_wr_en[k] = wr_en[k] &&
                            !((ZERO_REG != 0) && (wr_addr[k*ADDR_W +: ADDR_W] == ZERO_ADDR));
    end

    assign w_rsv_en = rsv_en && !((ZERO_REG != 0) && (rsv_addr == ZERO_ADDR));

    // Ascending port order makes the highest-numbered port win on an address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_wr_en[k]) begin
                    r_mem[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    multi_port_reg_file_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (w_rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (w_wr_en),
        .wr_addr  (wr_addr),
        .busy     (busy)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_hit;

        assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];

        // A forwarded value is already current, so it also masks the busy flag.
        always_comb begin
            w_data = r_mem[w_addr];
            w_hit  = 1'b0;
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (w_wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == w_addr)) begin
                        w_data = wr_data[k*DATA_W +: DATA_W];
                        w_hit  = 1'b1;
                    end
                end
            end
            if ((ZERO_REG != 0) && (w_addr == ZERO_ADDR)) begin
                w_data = '0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = w_data;
        assign rd_busy[i]                  = busy[w_addr] & ~w_hit;
    end

endmodule

// File: tb/tb_multi_port_reg_file.sv
// Scoreboard bench: dut0 is a 2R2W bypassing file, dut1 a 2R1W file without bypass.
// Stimulus pushes hand-computed expectations; a monitor pops and compares on each sample strobe.
module tb_multi_port_reg_file;

    logic        clk;
    logic        rst;

    logic [9:0]  rdAddr;
    logic [63:0] rdData;
    logic [1:0]  rdBusy;
    logic [1:0]  wrEn;
    logic [9:0]  wrAddr;
    logic [63:0] wrData;
    logic        rsvEn;
    logic [4:0]  rsvAddr;
    logic [31:0] busyVec;

    logic [9:0]  rd1Addr;
    logic [63:0] rd1Data;
    logic [1:0]  rd1Busy;
    logic        wr1En;
    logic [4:0]  wr1Addr;
    logic [31:0] wr1Data;
    logic [31:0] busy1Vec;

    typedef struct {
        int          sel;
        logic [63:0] value;
        string       name;
    } expect_t;

    expect_t expQ[$];
    event    sampleEv;
    int      testsRun    = 0;
    int      testsFailed = 0;

    multi_port_reg_file #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
    ) dut0 (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rdAddr),
        .rd_data  (rdData),
        .rd_busy  (rdBusy),
        .wr_en    (wrEn),
        .wr_addr  (wrAddr),
        .wr_data  (wrData),
        .rsv_en   (rsvEn),
        .rsv_addr (rsvAddr),
        .busy     (busyVec)
    );

    multi_port_reg_file #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)
    ) dut1 (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd1Addr),
        .rd_data  (rd1Data),
        .rd_busy  (rd1Busy),
        .wr_en    (wr1En),
        .wr_addr  (wr1Addr),
        .wr_data  (wr1Data),
        .rsv_en   (1'b0),
        .rsv_addr (5'd0),
        .busy     (busy1Vec)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] getActual(int sel);
        case (sel)
            0:       return {32'd0, rdData[31:0]};
            1:       return {32'd0, rdData[63:32]};
            2:       return {62'd0, rdBusy};
            3:       return {32'd0, busyVec};
            4:       return {32'd0, rd1Data[31:0]};
            5:       return {32'd0, busy1Vec};
            6:       return {62'd0, rd1Busy};
            7:       return {32'd0, rd1Data[63:32]};
            default: return 64'hDEAD_DEAD_DEAD_DEAD;
        endcase
    endfunction

    // Compares one popped expectation against the DUT output it names.
    task automatic checkOutput(input expect_t e);
        logic [63:0] act;
        act = getActual(e.sel);
        testsRun++;
        if (act !== e.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.value);
        end
    endtask

    // Monitor: drains the expectation queue each time stimulus strobes a sample.
    initial begin
        expect_t e;
        forever begin
            @(sampleEv);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic expectVal(input int sel, input logic [63:0] v, input string name);
        expect_t e;
        e.sel   = sel;
        e.value = v;
        e.name  = name;
        expQ.push_back(e);
    endtask

    // Samples 2 ns after the falling edge, well clear of the rising edge.
    task automatic sampleNow();
        #2;
        ->sampleEv;
        #1;
    endtask

    // Drives dut0 on the falling edge; dut1 inputs are set by the caller afterwards.
    task automatic applyStimulus(input logic [1:0]  we,
                                 input logic [4:0]  wa0, input logic [31:0] wd0,
                                 input logic [4:0]  wa1, input logic [31:0] wd1,
                                 input logic        rEn, input logic [4:0]  rA,
                                 input logic [4:0]  ra0, input logic [4:0]  ra1);
        @(negedge clk);
        wrEn    = we;
        wrAddr  = {wa1, wa0};
        wrData  = {wd1, wd0};
        rsvEn   = rEn;
        rsvAddr = rA;
        rdAddr  = {ra1, ra0};
    endtask

    initial begin
        rst     = 1'b0;
        wrEn    = '0;
        wrAddr  = '0;
        wrData  = '0;
        rsvEn   = 1'b0;
        rsvAddr = '0;
        rdAddr  = '0;
        wr1En   = 1'b0;
        wr1Addr = '0;
        wr1Data = '0;
        rd1Addr = {5'd9, 5'd2};

        // Reset state while reset is held low.
        #2;
        rdAddr = {5'd9, 5'd3};
        expectVal(0, 64'h0, "resetRd0");
        expectVal(1, 64'h0, "resetRd1");
        expectVal(2, 64'h0, "resetRdBusy");
        expectVal(3, 64'h0, "resetBusy");
        expectVal(4, 64'h0, "resetNoBypassRd0");
        expectVal(7, 64'h0, "resetNoBypassRd1");
        expectVal(6, 64'h0, "resetNoBypassRdBusy");
        ->sampleEv;
        #20;
        rst = 1'b1;

        // Writes to r0 are dropped and never forwarded.
        applyStimulus(2'b01, 5'd0, 32'h1234_5678, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
        expectVal(0, 64'h0, "zeroNoBypass");
        sampleNow();
        applyStimulus(2'b01, 5'd1, 32'h1111_1111, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd1);
        expectVal(1, 64'h1111_1111, "r1Bypass");
        sampleNow();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd1);
        expectVal(0, 64'h0, "r0Read");
        expectVal(1, 64'h1111_1111, "r1Read");
        sampleNow();

        // Same-cycle write to r2 on both files: forwarded on dut0, old value on dut1.
        applyStimulus(2'b01, 5'd2, 32'h2222_2222, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd1);
        wr1En   = 1'b1;
        wr1Addr = 5'd2;
        wr1Data = 32'h2222_2222;
        expectVal(0, 64'h2222_2222, "bypassOn");
        expectVal(4, 64'h0, "bypassOff");
        sampleNow();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd1);
        wr1En = 1'b0;
        expectVal(0, 64'h2222_2222, "r2Read");
        expectVal(4, 64'h2222_2222, "r2AfterEdgeNoBypass");
        sampleNow();

        // Both write ports hit r5: port 1 wins for bypass and storage.
        applyStimulus(2'b11, 5'd5, 32'hAAAA_AAAA, 5'd5, 32'hBBBB_BBBB, 1'b0, 5'd0, 5'd2, 5'd5);
        expectVal(1, 64'hBBBB_BBBB, "dualBypass");
        sampleNow();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd5);
        expectVal(1, 64'hBBBB_BBBB, "dualWrite");
        sampleNow();

        // Scoreboard: reserve r7, then clear it with a write.
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7);
        expectVal(2, 64'h0, "rsvBeforeEdge");
        sampleNow();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        expectVal(2, 64'h3, "rsvRdBusy");
        expectVal(3, 64'h80, "rsvBusyVec");
        sampleNow();
        applyStimulus(2'b01, 5'd7, 32'h7, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        expectVal(0, 64'h7, "r7Bypass");
        expectVal(2, 64'h0, "writeMasksRdBusy");
        expectVal(3, 64'h80, "busyBeforeClear");
        sampleNow();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3);
        expectVal(3, 64'h0, "busyCleared");
        expectVal(0, 64'h7, "r7Read");
        sampleNow();

        // Reserve and write r7 together: busy stays set, data still stored.
        applyStimulus(2'b01, 5'd7, 32'h8, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd3);
        sampleNow();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd7, 5'd3);
        expectVal(3, 64'h80, "rsvWinsOverWrite");
        expectVal(0, 64'h8, "rsvWriteStored");
        expectVal(2, 64'h1, "rsvWriteRdBusy");
        sampleNow();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3);
        expectVal(3, 64'h80, "rsvZeroIgnored");
        sampleNow();

        // Async reset between edges with live data and a busy register.
        applyStimulus(2'b01, 5'd3, 32'h3333_3333, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7);
        sampleNow();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7);
        expectVal(0, 64'h3333_3333, "r3BeforeReset");
        expectVal(3, 64'h88, "busyBeforeReset");
        sampleNow();
        rst = 1'b0;
        #1;
        expectVal(0, 64'h0, "asyncResetR3");
        expectVal(1, 64'h0, "asyncResetR7");
        expectVal(3, 64'h0, "asyncResetBusy");
        expectVal(2, 64'h0, "asyncResetRdBusy");
        expectVal(4, 64'h0, "asyncResetNoBypassR2");
        expectVal(5, 64'h0, "asyncResetNoBypassBusy");
        ->sampleEv;
        #1;
        rst = 1'b1;

        #5;
        while (expQ.size() > 0) begin
            expect_t e;
            e = expQ.pop_front();
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: got unchecked expected sampled", e.name);
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
